// File: rtl/smc_counter_lite19.sv
// Timing counter stage for the lite SMC: captures per-access timing and
// runs the CSLE / WS / CSTE down-counters feeding the state machine.
module smc_counter_lite19 #(
    parameter int WS_W = 8,
    parameter int TE_W = 2
) (
    input  logic            sys_clk19,
    input  logic            sys_reset19,
    input  logic            valid_access19,
    input  logic            le_enable19,
    input  logic            ws_enable19,
    input  logic            cste_enable19,
    input  logic            smc_done19,
    input  logic            mac_done19,
    input  logic [TE_W-1:0] cfg_csle19,
    input  logic [WS_W-1:0] cfg_ws19,
    input  logic [TE_W-1:0] cfg_cste19,
    input  logic [TE_W-1:0] cfg_oete19,
    output logic [TE_W-1:0] r_csle_count19,
    output logic [WS_W-1:0] r_ws_count19,
    output logic [TE_W-1:0] r_cste_count19,
    output logic [TE_W-1:0] r_csle_store19,
    output logic [WS_W-1:0] r_ws_store19,
    output logic [TE_W-1:0] r_cste_store19,
    output logic [TE_W-1:0] r_oete_store19
);

    logic            beat_reload;
    logic [TE_W-1:0] csle_next;
    logic [WS_W-1:0] ws_next;
    logic [TE_W-1:0] cste_next;

    // A finished beat of a multi-beat access restarts from the stored timing.
    assign beat_reload = smc_done19 & ~mac_done19 & ~valid_access19;

    always_comb begin
        csle_next = r_csle_count19;
        ws_next   = r_ws_count19;
        cste_next = r_cste_count19;
        if (valid_access19) begin
            csle_next = cfg_csle19;
            ws_next   = cfg_ws19;
            cste_next = cfg_cste19;
        end else if (beat_reload) begin
            csle_next = r_csle_store19;
            ws_next   = r_ws_store19;
            cste_next = r_cste_store19;
        end else begin
            if (le_enable19 && (r_csle_count19 != '0))
                csle_next = r_csle_count19 - TE_W'(1);
            if (ws_enable19 && (r_ws_count19 != '0))
                ws_next = r_ws_count19 - WS_W'(1);
            if (cste_enable19 && (r_cste_count19 != '0))
                cste_next = r_cste_count19 - TE_W'(1);
        end
    end

    always_ff @(posedge sys_clk19) begin
        if (sys_reset19) begin
            r_csle_count19 <= '0;
            r_ws_count19   <= '0;
            r_cste_count19 <= '0;
        end else begin
            r_csle_count19 <= csle_next;
            r_ws_count19   <= ws_next;
            r_cste_count19 <= cste_next;
        end
    end

    always_ff @(posedge sys_clk19) begin
        if (sys_reset19) begin
            r_csle_store19 <= '0;
            r_ws_store19   <= '0;
            r_cste_store19 <= '0;
            r_oete_store19 <= '0;
        end else if (valid_access19) begin
            r_csle_store19 <= cfg_csle19;
            r_ws_store19   <= cfg_ws19;
            r_cste_store19 <= cfg_cste19;
            r_oete_store19 <= cfg_oete19;
        end
    end

endmodule

// File: tb/tb_smc_counter_lite19.sv
// Scoreboard bench for smc_counter_lite19: driver pushes model results,
// monitor pops and compares one entry per clock edge.
module tb_smc_counter_lite19;

    logic       clk;
    logic       rst;
    logic       va, le, wse, ce, sd, md;
    logic [1:0] c_csle, c_cste, c_oete;
    logic [7:0] c_ws;
    logic [1:0] o_csle, o_cste, o_scsle, o_scste, o_soete;
    logic [7:0] o_ws, o_sws;

    typedef struct {
        int csle; int ws; int cste;
        int s_csle; int s_ws; int s_cste; int s_oete;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // reference model state: counters [csle, ws, cste], stores [csle, ws, cste, oete]
    int   m_cnt[3];
    int   m_st[4];

    smc_counter_lite19 #(.WS_W(8), .TE_W(2)) dut (
        .sys_clk19      (clk),
        .sys_reset19    (rst),
        .valid_access19 (va),
        .le_enable19    (le),
        .ws_enable19    (wse),
        .cste_enable19  (ce),
        .smc_done19     (sd),
        .mac_done19     (md),
        .cfg_csle19     (c_csle),
        .cfg_ws19       (c_ws),
        .cfg_cste19     (c_cste),
        .cfg_oete19     (c_oete),
        .r_csle_count19 (o_csle),
        .r_ws_count19   (o_ws),
        .r_cste_count19 (o_cste),
        .r_csle_store19 (o_scsle),
        .r_ws_store19   (o_sws),
        .r_cste_store19 (o_scste),
        .r_oete_store19 (o_soete)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input bit r, input bit a, input bit l, input bit w,
                       input bit c, input bit s, input bit m,
                       input int cl, input int cw, input int cc, input int co);
        exp_t e;
        int   en[3];
        @(negedge clk);
        rst = r; va = a; le = l; wse = w; ce = c; sd = s; md = m;
        c_csle = 2'(cl); c_ws = 8'(cw); c_cste = 2'(cc); c_oete = 2'(co);
        en[0] = int'(l); en[1] = int'(w); en[2] = int'(c);
        if (r) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            foreach (m_st[i]) m_st[i] = 0;
        end else if (a) begin
            m_st[0] = cl; m_st[1] = cw; m_st[2] = cc; m_st[3] = co;
            m_cnt[0] = cl; m_cnt[1] = cw; m_cnt[2] = cc;
        end else if (s && !m) begin
            for (int i = 0; i < 3; i++) m_cnt[i] = m_st[i];
        end else begin
            for (int i = 0; i < 3; i++)
                if (en[i] != 0 && m_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
        end
        e.csle = m_cnt[0]; e.ws = m_cnt[1]; e.cste = m_cnt[2];
        e.s_csle = m_st[0]; e.s_ws = m_st[1];
        e.s_cste = m_st[2]; e.s_oete = m_st[3];
        q.push_back(e);
    endtask

    task automatic idle(input bit l, input bit w, input bit c);
        cyc(0, 0, l, w, c, 0, 0,
            int'($urandom_range(3)), int'($urandom_range(255)),
            int'($urandom_range(3)), int'($urandom_range(3)));
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("csle_count", int'(o_csle), e.csle);
                chk("ws_count", int'(o_ws), e.ws);
                chk("cste_count", int'(o_cste), e.cste);
                chk("csle_store", int'(o_scsle), e.s_csle);
                chk("ws_store", int'(o_sws), e.s_ws);
                chk("cste_store", int'(o_scste), e.s_cste);
                chk("oete_store", int'(o_soete), e.s_oete);
            end
        end
    end

    initial begin : driver
        rst = 1; va = 0; le = 0; wse = 0; ce = 0; sd = 0; md = 0;
        c_csle = 0; c_ws = 0; c_cste = 0; c_oete = 0;
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 3, 200, 3, 3);
        // reset wins over a simultaneous load
        cyc(0, 1, 0, 0, 0, 0, 0, 3, 77, 2, 1);
        cyc(1, 1, 1, 1, 1, 0, 0, 2, 9, 1, 3);
        // load then count
        cyc(0, 1, 1, 1, 1, 0, 0, 2, 3, 1, 1);
        cyc(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0, 3, 9, 3, 3);
        cyc(0, 0, 0, 1, 0, 0, 0, 1, 5, 2, 0);
        cyc(0, 0, 0, 1, 0, 0, 0, 2, 6, 0, 2);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // beat reload, then last beat with no reload
        cyc(0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
        repeat (4) idle(1, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 1, 3, 3, 3, 3);
        cyc(0, 0, 0, 0, 0, 0, 0, 3, 3, 3, 3);
        // back-to-back: load beats reload and decrement
        cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 1, 0, 3, 255, 2, 2);
        repeat (6) idle(0, 0, 0);
        repeat (300) idle(1, 1, 1);
        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            cyc(($urandom_range(63) == 0), ($urandom_range(7) == 0),
                ($urandom_range(3) != 0), ($urandom_range(3) != 0),
                ($urandom_range(3) != 0), ($urandom_range(9) == 0),
                ($urandom_range(1) == 0),
                int'($urandom_range(3)), int'($urandom_range(255)),
                int'($urandom_range(3)), int'($urandom_range(3)));
        end
        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/smc_counter_lite19.md
Name: smc_counter_lite19

Overview:
- Timing counter stage for the lite static memory controller. It sits directly upstream of the SMC state machine.
- It captures per-access timing configuration when a new access is accepted. It then runs the chip-select leading-edge (CSLE), wait-state (WS) and chip-select trailing-edge (CSTE) down-counters under the enables the state machine returns.
- It supplies the registered counts and stored timings that drive the state machine's transitions, done, and latch-data decisions.

Parameters:
- WS_W, 8, width of wait-state config and counter. Must be 8 for the lite state machine.
- TE_W, 2, width of CSLE/CSTE/OETE config, counters and stores. Must be 2.

Ports:
- sys_clk19  in  1  system clock
- sys_reset19  in  1  synchronous reset, active high
- valid_access19  in  1  new access accepted; load config this cycle
- le_enable19  in  1  CSLE counter decrement enable
- ws_enable19  in  1  WS counter decrement enable
- cste_enable19  in  1  CSTE counter decrement enable
- smc_done19  in  1  last cycle of the current beat
- mac_done19  in  1  all beats of a multiple access complete
- cfg_csle19  in  TE_W  CS leading-edge delay for the new access
- cfg_ws19  in  WS_W  wait states for the new access
- cfg_cste19  in  TE_W  CS trailing-edge delay for the new access
- cfg_oete19  in  TE_W  read-strobe trailing-edge offset before CS
- r_csle_count19  out  TE_W  CSLE counter
- r_ws_count19  out  WS_W  WS counter
- r_cste_count19  out  TE_W  CSTE counter
- r_csle_store19  out  TE_W  stored CSLE for the access
- r_ws_store19  out  WS_W  stored WS for the access
- r_cste_store19  out  TE_W  stored CSTE for the access
- r_oete_store19  out  TE_W  stored OETE for the access

Behaviour:
- All outputs are registered and update on the posedge of sys_clk19. There are no combinational paths from inputs to outputs.
- Reset: sys_reset19 high at a posedge clears every counter and store to 0. Reset takes priority over all other events. Reset mid-access abandons the access with no residue.
- Store update:
  - valid_access19=1: all four stores load their cfg_* values.
  - Otherwise: all stores hold.
- Counter update priority, highest first:
  1. Load: valid_access19=1. Each counter loads its cfg_* value, not the old store. Decrement enables in the same cycle are ignored.
  2. Beat reload: smc_done19=1, mac_done19=0, valid_access19=0. Each counter reloads from its store for the next beat.
  3. Decrement: per counter, if its enable is 1 and the count is nonzero, count-1.
  4. Hold: otherwise the counter keeps its value.
- Counters saturate at 0. A decrement request at 0 leaves 0; there is no wrap-around to the maximum value.
- The three counters decrement independently. Simultaneous enables decrement all eligible counters in the same cycle.
- Latency: counts loaded at edge N are visible at N+1. The first decrement is seen at N+2 if the enable was high during cycle N+1.
- smc_done19 with mac_done19=1 and no valid_access19: no reload. Counters hold at their current (zero) values.
- Back-to-back access (valid_access19 and smc_done19 together): load wins and uses the new cfg values.
- cfg_* inputs are sampled only on valid_access19. Changes at any other time have no effect.

Test Plan:
- Reset: drive nonzero counts, then sys_reset19=1 for one edge -> all 7 outputs read 0 on the next cycle, even with valid_access19=1 in the same cycle.
- Load and count: cfg_csle=2, cfg_ws=3, cfg_cste=1, cfg_oete=1, pulse valid_access19; then le_enable19 for 2 cycles, ws_enable19 for 4 cycles, cste_enable19 for 2 cycles ->
  - csle counts 2,1,0.
  - ws counts 3,2,1,0,0 (saturates).
  - cste counts 1,0,0.
  - Stores stay 2/3/1/1 throughout.
- Multi-beat reload: after the first beat reaches zero, assert smc_done19=1 with mac_done19=0 -> counters return to 2/3/1 the next cycle. Repeat with mac_done19=1 -> counters stay 0.
- Back-to-back priority: smc_done19=1, mac_done19=0, valid_access19=1 with new cfg_ws=8'hFF, and ws_enable19=1 in the same cycle -> r_ws_count19=8'hFF and r_ws_store19=8'hFF; no decrement or old-store reload occurs.
- Config isolation: change cfg_* every cycle without valid_access19 -> stores and counters unaffected. Max values cfg_ws=255 and cfg_csle=3 load and count down fully without overflow.
